// File: rtl/pll_sim_model_if.sv
// Control and status bundle for pll_sim_model: standby, output gating,
// dynamic phase-step request, divided clocks and lock status.
interface pll_sim_model_if #(
    parameter int NUM_OUTPUTS = 4,
    parameter int SEL_WIDTH   = 2
);
    logic                   stdby;
    logic [NUM_OUTPUTS-1:0] out_enable;
    logic                   phase_step;
    logic                   phase_dir;
    logic [SEL_WIDTH-1:0]   phase_sel;
    logic [NUM_OUTPUTS-1:0] clk_out;
    logic                   lock;
    logic                   lock_sticky;

    modport master (
        output stdby, out_enable, phase_step, phase_dir, phase_sel,
        input  clk_out, lock, lock_sticky
    );

    modport slave (
        input  stdby, out_enable, phase_step, phase_dir, phase_sel,
        output clk_out, lock, lock_sticky
    );
endinterface

// File: rtl/pll_sim_model.sv
// Cycle-based ECP5-style PLL model: divided/phase-offset clocks, lock, standby.
// Define PLL_SIM_PHASE_STEP_EN to build dynamic per-channel phase stepping.
module pll_sim_model #(
    parameter int                               NUM_OUTPUTS = 4,
    parameter int                               DIV_WIDTH   = 8,
    parameter int                               SEL_WIDTH   = 2,
    parameter logic [NUM_OUTPUTS*DIV_WIDTH-1:0] DIVS        = {NUM_OUTPUTS{DIV_WIDTH'(8)}},
    parameter logic [NUM_OUTPUTS*DIV_WIDTH-1:0] CPHASES     = '0,
    parameter int                               LOCK_DELAY  = 200
) (
    input logic            clk,
    input logic            reset,
    pll_sim_model_if.slave pif
);

    localparam int LD  = (LOCK_DELAY < 1) ? 1 : LOCK_DELAY;
    localparam int LCW = $clog2(LD + 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LD - 1);

    typedef enum logic [1:0] {ACQUIRE, LOCKED, STANDBY} state_t;

    state_t                 state_q, state_d;
    logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [DIV_WIDTH-1:0]   cnt_q [NUM_OUTPUTS];
    logic [DIV_WIDTH-1:0]   cnt_d [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] clk_q, clk_d;
    logic                   lock_q, sticky_q;
    logic                   run;
    logic [NUM_OUTPUTS-1:0] step_adv, step_ret;

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input int i);
        logic [DIV_WIDTH-1:0] d;
        d = DIVS[i*DIV_WIDTH +: DIV_WIDTH];
        return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] pre_of(input int i);
        logic [DIV_WIDTH-1:0] d, c;
        d = clamp_div(i);
        c = CPHASES[i*DIV_WIDTH +: DIV_WIDTH] % d;
        return (c == '0) ? '0 : d - c;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] high_of(input int i);
        logic [DIV_WIDTH-1:0] d;
        d = clamp_div(i);
        return (d >> 1) + {{(DIV_WIDTH-1){1'b0}}, d[0]};
    endfunction

    function automatic logic [DIV_WIDTH-1:0] wrap_inc1(input logic [DIV_WIDTH-1:0] c,
                                                       input logic [DIV_WIDTH-1:0] d);
        return (c == d - DIV_WIDTH'(1)) ? '0 : c + DIV_WIDTH'(1);
    endfunction

    // Advance by two with compare-and-clear; covers the two wrap positions.
    function automatic logic [DIV_WIDTH-1:0] wrap_inc2(input logic [DIV_WIDTH-1:0] c,
                                                       input logic [DIV_WIDTH-1:0] d);
        if (c == d - DIV_WIDTH'(1)) return DIV_WIDTH'(1);
        if (c == d - DIV_WIDTH'(2)) return '0;
        return c + DIV_WIDTH'(2);
    endfunction

    // Standby re-enters acquisition through the same lock-count test, so the
    // release edge already counts toward LOCK_DELAY.
    always_comb begin
        state_d = state_q;
        if (pif.stdby) begin
            state_d = STANDBY;
        end else begin
            case (state_q)
                ACQUIRE, STANDBY: state_d = (lock_cnt_q == LOCK_LAST) ? LOCKED : ACQUIRE;
                LOCKED:           state_d = LOCKED;
                default:          state_d = ACQUIRE;
            endcase
        end
        run        = (state_q == LOCKED) && (state_d == LOCKED);
        lock_cnt_d = (state_d == ACQUIRE) ? lock_cnt_q + LCW'(1) : '0;
    end

`ifdef PLL_SIM_PHASE_STEP_EN
    logic step_q;
    logic step_fire;

    always_ff @(posedge clk) begin
        if (reset) step_q <= 1'b0;
        else       step_q <= pif.phase_step;
    end

    assign step_fire = run & pif.phase_step & ~step_q;

    always_comb begin
        step_adv = '0;
        step_ret = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (step_fire && (int'(pif.phase_sel) == i)) begin
                step_adv[i] = ~pif.phase_dir;
                step_ret[i] = pif.phase_dir;
            end
        end
    end
`else
    logic unused_step;
    assign unused_step = ^{pif.phase_step, pif.phase_dir, pif.phase_sel};
    assign step_adv    = '0;
    assign step_ret    = '0;
`endif

    always_comb begin
        clk_d = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            cnt_d[i] = pre_of(i);
            if (run) begin
                clk_d[i] = pif.out_enable[i] & (cnt_q[i] < high_of(i));
                if (step_adv[i])      cnt_d[i] = wrap_inc2(cnt_q[i], clamp_div(i));
                else if (step_ret[i]) cnt_d[i] = cnt_q[i];
                else                  cnt_d[i] = wrap_inc1(cnt_q[i], clamp_div(i));
            end
        end
    end

    // Register stage: state, counters and registered output pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACQUIRE;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            sticky_q   <= 1'b0;
            clk_q      <= '0;
            for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= pre_of(i);
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= (state_d == LOCKED);
            sticky_q   <= sticky_q | (state_d == LOCKED);
            clk_q      <= clk_d;
            for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign pif.clk_out     = clk_q;
    assign pif.lock        = lock_q;
    assign pif.lock_sticky = sticky_q;

endmodule
